// File: rtl/lsu_pkg.sv
// Shared size codes, FSM encoding and byte-lane helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_RSVD = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsuState_t;

    // Natural alignment check; the reserved size is never aligned.
    function automatic logic isAligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: isAligned = 1'b1;
            SZ_HALF: isAligned = ~offset[0];
            SZ_WORD: isAligned = (offset == 2'b00);
            default: isAligned = 1'b0;
        endcase
    endfunction

    // Unshifted byte-enable mask for an access size.
    function automatic logic [BE_W-1:0] baseMask(input logic [1:0] size);
        case (size)
            SZ_BYTE: baseMask = BE_BYTE;
            SZ_HALF: baseMask = BE_HALF;
            SZ_WORD: baseMask = BE_WORD;
            default: baseMask = '0;
        endcase
    endfunction

    // Store data replicated across lanes; for an aligned access this equals the
    // lane data rotated by the byte offset, so every enabled lane holds the right byte.
    function automatic logic [DATA_W-1:0] laneData(input logic [1:0] size,
                                                   input logic [DATA_W-1:0] wdata);
        case (size)
            SZ_BYTE: laneData = {4{wdata[7:0]}};
            SZ_HALF: laneData = {2{wdata[15:0]}};
            default: laneData = wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load lane extract and zero/sign extension.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              isSigned,
    output logic [DATA_W-1:0] extData_c
);

    logic [DATA_W-1:0] shifted;

    // Shift the addressed lane down, then extend to a full word.
    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        extData_c = shifted;
        case (size)
            SZ_BYTE: extData_c = {{24{isSigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: extData_c = {{16{isSigned & shifted[15]}}, shifted[15:0]};
            default: extData_c = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the MEM stage and the word-wide data memory bus.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_adel,
    output logic              rsp_ades,
    output logic              rsp_buserr,
    output logic [ADDR_W-1:0] rsp_badaddr
);

    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsuState_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addrReg;
    logic [1:0]        sizeReg;
    logic              signedReg;
    logic              weReg;
    logic [DATA_W-1:0] extData;
    logic              accept;
    logic              aligned;

    assign accept  = req_valid & req_ready;
    assign aligned = isAligned(req_size, req_addr[1:0]);

    lsu_load_ext u_loadExt (
        .rdata     (mem_rdata),
        .offset    (addrReg[1:0]),
        .size      (sizeReg),
        .isSigned  (signedReg),
        .extData_c (extData)
    );

    // Access sequencer: accept, bus handshake with timeout, one-cycle response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            addrReg     <= '0;
            sizeReg     <= SZ_BYTE;
            signedReg   <= 1'b0;
            weReg       <= 1'b0;
            req_ready   <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_adel    <= 1'b0;
            rsp_ades    <= 1'b0;
            rsp_buserr  <= 1'b0;
            rsp_badaddr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        addrReg   <= req_addr;
                        sizeReg   <= req_size;
                        signedReg <= req_signed;
                        weReg     <= req_we;
                        if (aligned) begin
                            state     <= ST_BUS;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= BE_W'(baseMask(req_size) << req_addr[1:0]);
                            mem_wdata <= laneData(req_size, req_wdata);
                        end else begin
                            state       <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_data    <= '0;
                            rsp_adel    <= ~req_we;
                            rsp_ades    <= req_we;
                            rsp_badaddr <= req_addr;
                        end
                    end
                end
                ST_BUS: begin
                    if (mem_ack) begin
                        state     <= ST_RESP;
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= weReg ? '0 : extData;
                    end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
                        state       <= ST_RESP;
                        mem_req     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= '0;
                        rsp_buserr  <= 1'b1;
                        rsp_badaddr <= addrReg;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    req_ready   <= 1'b1;
                    rsp_valid   <= 1'b0;
                    rsp_data    <= '0;
                    rsp_adel    <= 1'b0;
                    rsp_ades    <= 1'b0;
                    rsp_buserr  <= 1'b0;
                    rsp_badaddr <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
